// File: rtl/bram_frame_ctrl_pkg.sv
// Package: bram_frame_pkg
// Shared types and constants for the stream-to-BRAM frame buffer controller.
//   frame_state_e : controller state (FILL while writing a frame, DRAIN while reading it)
//   LAST_IDX      : index of the final word for the default 1600-word frame
//   last_idx()    : final word index for an arbitrary frame length
package bram_frame_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } frame_state_e;

    localparam int unsigned DEFAULT_FRAME_LEN = 1600;
    localparam int unsigned LAST_IDX          = DEFAULT_FRAME_LEN - 1;

    function automatic int unsigned last_idx(input int unsigned frame_len);
        return frame_len - 1;
    endfunction

endpackage

// File: rtl/bram_frame_ctrl_if.sv
// Interface: bram_frame_ctrl_if
// One valid/ready word stream with an end-of-frame marker.
//   valid : beat valid (producer)
//   ready : beat accepted when valid & ready (consumer)
//   data  : WIDTH-bit word (producer)
//   last  : end-of-frame marker (producer)
// modport master = producer side, modport slave = consumer side.
interface bram_frame_ctrl_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );

endinterface

// File: rtl/bram_rd_skid.sv
// Module: bram_rd_skid
// Two-entry FIFO that absorbs the one-cycle RAM read latency on the drain path.
// The head entry always lives in slot0 so the head data is a plain register.
//   clk, rst_n : clock, synchronous active-low reset (clears occupancy only)
//   push       : write push_data this cycle
//   push_data  : {last, data} entry
//   pop        : remove the head entry this cycle (only when head_valid)
//   head_valid : FIFO non-empty
//   head_data  : head entry
//   count      : number of stored entries (0..2)
module bram_rd_skid #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = push_data;
                end else begin
                    slot1_d = push_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new entry goes behind whatever remains.
                if (count_q == 2'd2) begin
                    slot0_d = slot1_q;
                    slot1_d = push_data;
                end else begin
                    slot0_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign head_valid = (count_q != 2'd0);
    assign head_data  = slot0_q;
    assign count      = count_q;

endmodule

// File: rtl/bram_frame_ctrl.sv
// Module: bram_frame_ctrl
// Stream-to-BRAM frame buffer controller. Fills a single-port RAM (1-cycle registered
// read, read-first) with one FRAME_LEN-word frame from the input stream, then drains
// it in address order to the output stream without losing data under back-pressure.
//   clk, rst_n : clock, synchronous active-low reset
//   s          : input stream (slave); s.last is only checked, never used for length
//   m          : output stream (master); m.last marks word FRAME_LEN-1
//   ram_we, ram_addr, ram_din, ram_dout : RAM port (dout valid 1 cycle after address)
//   frame_done : 1-cycle pulse after the final output beat is consumed
//   len_err    : sticky s.last misplacement flag, cleared only by reset
module bram_frame_ctrl
    import bram_frame_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 1600,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned FRAME_LEN  = 1600
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bram_frame_ctrl_if.slave      s,
    bram_frame_ctrl_if.master     m,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_din,
    input  logic [WIDTH-1:0]      ram_dout,
    output logic                  frame_done,
    output logic                  len_err
);

    if (FRAME_LEN < 2 || FRAME_LEN > DEPTH) begin : g_bad_frame_len
        $error("bram_frame_ctrl: FRAME_LEN must satisfy 2 <= FRAME_LEN <= DEPTH");
    end
    if (64'(last_idx(FRAME_LEN)) >= (64'(1) << ADDR_WIDTH)) begin : g_bad_addr_width
        $error("bram_frame_ctrl: FRAME_LEN-1 does not fit in ADDR_WIDTH bits");
    end

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(last_idx(FRAME_LEN));

    frame_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                  rd_done_q, rd_done_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  len_err_q, len_err_d;
    logic                  frame_done_q, frame_done_d;

    logic                  head_valid;
    logic [WIDTH:0]        head_data;
    logic [1:0]            skid_count;
    logic                  s_beat;
    logic                  pop;
    logic                  final_pop;
    logic                  issue;
    logic [2:0]            occ;

    assign s_beat    = (state_q == FILL) && s.valid;
    assign pop       = head_valid && m.ready;
    assign final_pop = pop && head_data[WIDTH];

    // Entries held or in flight once this cycle's pop has left; a new read may only
    // issue if it still has a skid slot waiting for it.
    assign occ   = {1'b0, skid_count} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue = (state_q == DRAIN) && !rd_done_q && (occ < 3'd2);

    // rd_done_q rises on the cycle the final read's data is pushed, so it doubles as
    // that entry's last flag; no earlier push can see it set.
    bram_rd_skid #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rd_pend_q),
        .push_data  ({rd_done_q, ram_dout}),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (skid_count)
    );

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        rd_done_d    = rd_done_q;
        rd_pend_d    = 1'b0;
        len_err_d    = len_err_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            FILL: begin
                if (s_beat) begin
                    if (s.last != (wr_cnt_q == LastAddr)) begin
                        len_err_d = 1'b1;
                    end
                    if (wr_cnt_q == LastAddr) begin
                        wr_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                rd_pend_d = issue;
                if (issue) begin
                    // Hold the counter on the last index so the address stays in range.
                    if (rd_cnt_q == LastAddr) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
                if (final_pop) begin
                    state_d      = FILL;
                    rd_cnt_d     = '0;
                    rd_done_d    = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rd_done_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            len_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_done_q    <= rd_done_d;
            rd_pend_q    <= rd_pend_d;
            len_err_q    <= len_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s.ready    = (state_q == FILL);
    assign ram_we     = rst_n && s_beat;
    assign ram_addr   = (state_q == FILL) ? wr_cnt_q : rd_cnt_q;
    assign ram_din    = s.data;

    assign m.valid    = head_valid;
    assign m.data     = head_data[WIDTH-1:0];
    assign m.last     = head_valid && head_data[WIDTH];

    assign frame_done = frame_done_q;
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_bram_frame_ctrl.sv
// Testbench: tb_bram_frame_ctrl
// Directed vectors against two controller instances, each with a behavioural
// read-first RAM: u_dut_a (FRAME_LEN=4, 16-word RAM) and u_dut_b (FRAME_LEN=1600).
module tb_bram_frame_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bram_frame_ctrl_if #(.WIDTH(32)) sa ();
    bram_frame_ctrl_if #(.WIDTH(32)) ma ();
    bram_frame_ctrl_if #(.WIDTH(32)) sb ();
    bram_frame_ctrl_if #(.WIDTH(32)) mb ();

    logic        ram_we_a, fd_a, le_a;
    logic [3:0]  ram_addr_a;
    logic [31:0] ram_din_a, ram_dout_a;
    logic        ram_we_b, fd_b, le_b;
    logic [10:0] ram_addr_b;
    logic [31:0] ram_din_b, ram_dout_b;

    logic [31:0] ram_a [0:15];
    logic [31:0] ram_b [0:1599];

    bram_frame_ctrl #(
        .WIDTH      (32),
        .DEPTH      (16),
        .ADDR_WIDTH (4),
        .FRAME_LEN  (4)
    ) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (sa),
        .m          (ma),
        .ram_we     (ram_we_a),
        .ram_addr   (ram_addr_a),
        .ram_din    (ram_din_a),
        .ram_dout   (ram_dout_a),
        .frame_done (fd_a),
        .len_err    (le_a)
    );

    bram_frame_ctrl #(
        .WIDTH      (32),
        .DEPTH      (1600),
        .ADDR_WIDTH (11),
        .FRAME_LEN  (1600)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (sb),
        .m          (mb),
        .ram_we     (ram_we_b),
        .ram_addr   (ram_addr_b),
        .ram_din    (ram_din_b),
        .ram_dout   (ram_dout_b),
        .frame_done (fd_b),
        .len_err    (le_b)
    );

    // Single-port RAMs, read-first.
    always @(posedge clk) begin
        if (ram_we_a) ram_a[ram_addr_a] <= ram_din_a;
        ram_dout_a <= ram_a[ram_addr_a];
    end
    always @(posedge clk) begin
        if (ram_we_b) ram_b[ram_addr_b] <= ram_din_b;
        ram_dout_b <= ram_b[ram_addr_b];
    end

    int n_vec = 0;
    int n_err = 0;
    int occ_viol = 0;

    always @(negedge clk) begin
        if (int'(u_dut_a.rd_pend_q) + int'(u_dut_a.skid_count) > 2) occ_viol++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Four beats into u_dut_a; optional idle cycle between beats.
    task automatic fill_a(input logic [31:0] base, input bit gaps, input int last_pos);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sa.valid = 1'b1;
            sa.data  = base + i;
            sa.last  = (i == last_pos);
            #1;
            check_eq("a_fill_we", ram_we_a, 1);
            check_eq("a_fill_addr", ram_addr_a, i);
            check_eq("a_fill_din", ram_din_a, base + i);
            if (gaps && i < 3) begin
                @(negedge clk);
                sa.valid = 1'b0;
                #1;
                check_eq("a_gap_we", ram_we_a, 0);
            end
        end
    endtask

    // mode 0: m.ready always 1; mode 1: m.ready pattern 1,0,0 repeating.
    task automatic drain_a(input logic [31:0] base, input int mode, input int ncyc,
                           input bit full);
        int k = 0;
        int fd = 0;
        int first_v = -1;
        int first_rdy = -1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            ma.ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #1;
            if (cyc == 0) begin
                check_eq("a_drain_s_ready", sa.ready, 0);
                check_eq("a_drain_we", ram_we_a, 0);
                sa.valid = 1'b0;
            end
            if (ma.valid) begin
                if (first_v < 0) first_v = cyc;
                check_eq("a_m_data", ma.data, base + k);
                check_eq("a_m_last", ma.last, (k == 3));
                if (ma.ready) k++;
            end
            if (fd_a) fd++;
            if (sa.ready && first_rdy < 0) first_rdy = cyc;
        end
        if (full) begin
            check_eq("a_beats", k, 4);
            check_eq("a_frame_done_cnt", fd, 1);
            if (mode == 0) begin
                check_eq("a_first_valid_cyc", first_v, 2);
                check_eq("a_drain_len", first_rdy, 6);
            end
        end
    endtask

    task automatic fill_b(input logic [31:0] base);
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            sb.valid = 1'b1;
            sb.data  = base + i;
            sb.last  = (i == 1599);
            #1;
            check_eq("b_fill_addr", ram_addr_b, i);
        end
    endtask

    task automatic drain_b(input logic [31:0] base);
        int k = 0;
        int fd = 0;
        int first_rdy = -1;
        int max_addr = 0;
        for (int cyc = 0; cyc < 1700; cyc++) begin
            @(negedge clk);
            sb.valid = 1'b0;
            mb.ready = 1'b1;
            #1;
            if (!sb.ready && int'(ram_addr_b) > max_addr) max_addr = int'(ram_addr_b);
            if (mb.valid && mb.ready) begin
                check_eq("b_m_data", mb.data, base + k);
                check_eq("b_m_last", mb.last, (k == 1599));
                k++;
            end
            if (fd_b) fd++;
            if (sb.ready) begin
                first_rdy = cyc;
                break;
            end
        end
        check_eq("b_beats", k, 1600);
        check_eq("b_drain_len", first_rdy, 1602);
        check_eq("b_max_addr", max_addr, 1599);
        check_eq("b_frame_done_cnt", fd, 1);
        check_eq("b_len_err", le_b, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sa.valid = 1'b1;
        sa.data  = 32'hDEAD_BEEF;
        sa.last  = 1'b0;
        ma.ready = 1'b0;
        sb.valid = 1'b0;
        sb.data  = '0;
        sb.last  = 1'b0;
        mb.ready = 1'b0;

        // Reset: no write even with s.valid high.
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_we", ram_we_a, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        sa.valid = 1'b0;
        #1;
        check_eq("rst_m_valid", ma.valid, 0);
        check_eq("rst_m_last", ma.last, 0);
        check_eq("rst_frame_done", fd_a, 0);
        check_eq("rst_len_err", le_a, 0);
        check_eq("rst_s_ready", sa.ready, 1);
        check_eq("rst_b_m_valid", mb.valid, 0);
        check_eq("rst_b_s_ready", sb.ready, 1);

        // 1: basic frame, full throughput.
        fill_a(32'hA0, 1'b0, 3);
        drain_a(32'hA0, 0, 40, 1'b1);
        check_eq("t1_len_err", le_a, 0);

        // 2: toggling back-pressure.
        fill_a(32'hC0, 1'b0, 3);
        drain_a(32'hC0, 1, 40, 1'b1);
        check_eq("t2_occupancy", occ_viol, 0);

        // 3: input gaps.
        fill_a(32'hD0, 1'b1, 3);
        drain_a(32'hD0, 0, 40, 1'b1);

        // 4: early s.last.
        fill_a(32'hE0, 1'b0, 1);
        check_eq("t4_len_err_set", le_a, 1);
        drain_a(32'hE0, 0, 40, 1'b1);
        check_eq("t4_len_err_sticky", le_a, 1);

        // 5: reset mid-drain, then a clean frame.
        fill_a(32'hF0, 1'b0, 3);
        drain_a(32'hF0, 0, 3, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_we", ram_we_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("t5_m_valid", ma.valid, 0);
        check_eq("t5_s_ready", sa.ready, 1);
        check_eq("t5_len_err_clr", le_a, 0);
        fill_a(32'hB0, 1'b0, 3);
        drain_a(32'hB0, 0, 40, 1'b1);

        // 6: two full-size frames.
        fill_b(32'h1000_0000);
        drain_b(32'h1000_0000);
        fill_b(32'h2000_0000);
        drain_b(32'h2000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
